// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mem_access_ctrl                                                   |
// | Brief  : Load/store front end decoding CPU addresses onto RAM port A or    |
// |          memory-mapped switches/LEDs, one request in flight at a time.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_access_ctrl #(
   parameter int          DATA_WIDTH = 16,
   parameter int          ADDR_WIDTH = 10,
   parameter logic [15:0] IO_BASE    = 16'hFF00
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [15:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_q,
   input  logic [9:0]            io_sw,
   output logic [9:0]            io_led
);

   localparam int          C_IO_W      = 10;
   localparam logic [16:0] C_RAM_LIMIT = 17'(2 ** ADDR_WIDTH);
   localparam logic [15:0] C_SW_ADDR   = IO_BASE;
   localparam logic [15:0] C_LED_ADDR  = IO_BASE + 16'd1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]            state_q,     state_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_data_q,  ram_data_d;
   logic                  ram_we_q,    ram_we_d;
   logic                  is_store_q,  is_store_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q,   rsp_err_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [C_IO_W-1:0]     io_led_q,    io_led_d;
   logic [C_IO_W-1:0]     sw_meta_q;
   logic [C_IO_W-1:0]     sw_sync_q;

   logic                  w_accept;
   logic                  w_is_ram;
   logic                  w_is_sw;
   logic                  w_is_led;
   logic [DATA_WIDTH-1:0] w_sw_ext;
   logic [DATA_WIDTH-1:0] w_led_ext;

   assign req_ready = (state_q == S_IDLE) && !reset;
   assign w_accept  = req_valid && req_ready;

   // RAM window is checked first and never aliases into the unmapped gap above it
   assign w_is_ram  = ({1'b0, req_addr} < C_RAM_LIMIT);
   assign w_is_sw   = (req_addr == C_SW_ADDR);
   assign w_is_led  = (req_addr == C_LED_ADDR);

   assign w_sw_ext  = {{(DATA_WIDTH-C_IO_W){1'b0}}, sw_sync_q};
   assign w_led_ext = {{(DATA_WIDTH-C_IO_W){1'b0}}, io_led_q};

   always_comb begin
      state_d     = state_q;
      ram_addr_d  = ram_addr_q;
      ram_data_d  = ram_data_q;
      ram_we_d    = ram_we_q;
      is_store_d  = is_store_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      io_led_d    = io_led_q;

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               if (w_is_ram) begin
                  ram_addr_d = req_addr[ADDR_WIDTH-1:0];
                  ram_data_d = req_wdata;
                  ram_we_d   = req_we;
                  is_store_d = req_we;
                  state_d    = S_ISSUE;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = !(w_is_sw || w_is_led);
                  rsp_rdata_d = '0;
                  if (!req_we) begin
                     if (w_is_sw) begin
                        rsp_rdata_d = w_sw_ext;
                     end else if (w_is_led) begin
                        rsp_rdata_d = w_led_ext;
                     end
                  end else if (w_is_led) begin
                     io_led_d = req_wdata[C_IO_W-1:0];
                  end
                  state_d = S_RESP;
               end
            end
         end
         S_ISSUE: begin
            ram_we_d = 1'b0;
            if (is_store_q) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               state_d     = S_RESP;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // RAM read data is valid one cycle after the address was presented
            rsp_rdata_d = ram_q;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
         ram_we_q    <= 1'b0;
         is_store_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         io_led_q    <= '0;
      end else begin
         state_q     <= state_d;
         ram_addr_q  <= ram_addr_d;
         ram_data_q  <= ram_data_d;
         ram_we_q    <= ram_we_d;
         is_store_q  <= is_store_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         io_led_q    <= io_led_d;
      end
   end

   // Two-flop synchronizer for the asynchronous switch inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= io_sw;
         sw_sync_q <= sw_meta_q;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign ram_addr  = ram_addr_q;
   assign ram_data  = ram_data_q;
   assign ram_we    = ram_we_q;
   assign io_led    = io_led_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mem_access_ctrl                                                |
// | Brief  : Scoreboard bench for mem_access_ctrl with a behavioural RAM.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_access_ctrl;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic [9:0]  ram_addr;
   logic [15:0] ram_data;
   logic        ram_we;
   logic [15:0] ram_q;
   logic [9:0]  io_sw;
   logic [9:0]  io_led;

   mem_access_ctrl #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (10),
      .IO_BASE    (16'hFF00)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_we    (ram_we),
      .ram_q     (ram_q),
      .io_sw     (io_sw),
      .io_led    (io_led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem [0:1023];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   we_cnt = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (ram_we) we_cnt++;
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, e.rdata});
            chk("rsp_err",   {31'h0, rsp_err},   {31'h0, e.err});
            chk("rsp_cycle", cyc,                e.cyc);
         end
      end
   end

   // Called at a negedge; returns at the negedge of the cycle after the accept edge.
   task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rdata, input logic exp_err, input int lat,
                         input bit track);
      int tries;
      exp_t e;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      #1;
      tries = 0;
      while (!req_ready && tries < 20) begin
         @(negedge clk);
         #1;
         tries++;
      end
      if (!req_ready) begin
         n_vec++;
         n_fail++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 within 20 cycles");
      end else if (track) begin
         e.rdata = exp_rdata;
         e.err   = exp_err;
         e.cyc   = cyc + lat;
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain;
      int t;
      t = 0;
      while (sb.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      chk("drained", sb.size(), 0);
   endtask

   initial begin
      int accepts;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 16'h0;
      req_wdata = 16'h0;
      io_sw     = 10'h0;
      repeat (3) @(negedge clk);
      chk("ready_in_reset", {31'h0, req_ready}, 0);
      reset = 1'b0;
      #1;
      chk("reset_ready",  {31'h0, req_ready}, 1);
      chk("reset_rspv",   {31'h0, rsp_valid}, 0);
      chk("reset_ramwe",  {31'h0, ram_we},    0);
      chk("reset_ramadr", {22'h0, ram_addr},  0);
      chk("reset_led",    {22'h0, io_led},    0);
      @(negedge clk);

      // 1: RAM store then load
      do_req(1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b0, 2, 1'b1);
      chk("st_we_pulse", {31'h0, ram_we},   1);
      chk("st_ram_addr", {22'h0, ram_addr}, 32'h5);
      chk("st_ram_data", {16'h0, ram_data}, 32'h1234);
      @(negedge clk);
      chk("st_we_low",   {31'h0, ram_we},   0);
      do_req(1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 3, 1'b1);
      drain();

      // 2: top RAM word, then first address past the window
      do_req(1'b1, 16'h03FF, 16'hBEEF, 16'h0000, 1'b0, 2, 1'b1);
      do_req(1'b0, 16'h03FF, 16'h0000, 16'hBEEF, 1'b0, 3, 1'b1);
      do_req(1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 1, 1'b1);
      chk("err_ram_addr", {22'h0, ram_addr}, 32'h3FF);
      drain();

      // 3: LED register write and readback
      do_req(1'b1, 16'hFF01, 16'h02A5, 16'h0000, 1'b0, 1, 1'b1);
      chk("led_value", {22'h0, io_led}, 32'h2A5);
      do_req(1'b0, 16'hFF01, 16'h0000, 16'h02A5, 1'b0, 1, 1'b1);

      // Unmapped and read-only accesses: no side effects
      do_req(1'b1, 16'hFF00, 16'h03FF, 16'h0000, 1'b0, 1, 1'b1);
      do_req(1'b1, 16'h8000, 16'h0111, 16'h0000, 1'b1, 1, 1'b1);
      do_req(1'b0, 16'hFEFF, 16'h0000, 16'h0000, 1'b1, 1, 1'b1);
      do_req(1'b0, 16'hFF02, 16'h0000, 16'h0000, 1'b1, 1, 1'b1);
      chk("led_kept", {22'h0, io_led}, 32'h2A5);
      drain();

      // 4: synchronized switches
      io_sw = 10'h155;
      repeat (3) @(negedge clk);
      do_req(1'b0, 16'hFF00, 16'h0000, 16'h0155, 1'b0, 1, 1'b1);
      drain();

      // 5: req_valid held across back-to-back loads
      accepts   = 0;
      req_we    = 1'b0;
      req_addr  = 16'h0005;
      req_wdata = 16'h0;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1;
         #1;
         if (req_ready) begin
            exp_t e;
            chk("in_flight", sb.size(), 0);
            e.rdata = 16'h1234;
            e.err   = 1'b0;
            e.cyc   = cyc + 3;
            sb.push_back(e);
            accepts++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_accepts", accepts, 2);
      drain();

      // 6: reset asserted while a load waits on RAM
      do_req(1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0, 3, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ready",  {31'h0, req_ready}, 1);
      chk("rst_rspv",   {31'h0, rsp_valid}, 0);
      chk("rst_rdata",  {16'h0, rsp_rdata}, 0);
      chk("rst_ramadr", {22'h0, ram_addr},  0);
      chk("rst_ramdat", {16'h0, ram_data},  0);
      chk("rst_led",    {22'h0, io_led},    0);
      repeat (5) @(negedge clk);
      chk("ram_we_cycles", we_cnt, 2);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
